// File: rtl/ws2812b_arbiter.sv
// ws2812b_arbiter: round-robin share of one ws2812b driver write port with a post-write gap.
// Optional out-of-range drop check enabled by defining WS2812B_ARB_BOUNDS_CHECK_EN.
module ws2812b_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IDX_W      = 8,
  parameter int NB_LEDS    = 15,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*IDX_W-1:0] req_led,
  input  logic [N_REQ*24-1:0]    req_color,
  output logic [N_REQ-1:0]       req_ready,
  output logic [23:0]            color,
  output logic [31:0]            nb_led,
  output logic                   write,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);
  localparam int PW = $clog2(N_REQ);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  if (N_REQ < 2 || N_REQ > 8 || NB_LEDS < 1 || GAP_CYCLES < 0) begin : g_bad_params
    $error("ws2812b_arbiter: unsupported parameter set");
  end
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DROP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] last, win;
  logic [GW-1:0] gap, gap_nx;
  logic [IDX_W-1:0] win_led;
  logic [23:0] win_color;
  logic any, drop, accept;
  // scan farthest-first so the nearest valid requester after last wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last) + k) % N_REQ]) begin
        win = PW'((int'(last) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end
  assign win_led   = req_led[int'(win)*IDX_W +: IDX_W];
  assign win_color = req_color[int'(win)*24 +: 24];
  assign accept    = state == S_IDLE && any;
  assign req_ready = accept ? N_REQ'(1) << win : '0;
  assign write     = state == S_ISSUE;
  assign busy      = state != S_IDLE;
`ifdef WS2812B_ARB_BOUNDS_CHECK_EN
  assign drop = 32'(win_led) >= 32'(NB_LEDS);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (accept && drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop     = 1'b0;
  assign drop_cnt = '0;
`endif
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    case (state)
      S_IDLE:  state_nx = any ? (drop ? S_DROP : S_ISSUE) : S_IDLE;
      S_ISSUE: begin
        state_nx = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
        gap_nx   = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
      end
      S_GAP: begin
        state_nx = gap == '0 ? S_IDLE : S_GAP;
        gap_nx   = gap == '0 ? gap : gap - GW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      gap    <= '0;
      last   <= PW'(N_REQ - 1);
      color  <= '0;
      nb_led <= '0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
      if (accept) last <= win;
      if (accept && !drop) begin
        color  <= win_color;
        nb_led <= 32'(win_led);
      end
    end
  end
endmodule

// File: tb/tb_ws2812b_arbiter.sv
// tb_ws2812b_arbiter: directed checks of grant order, write timing, gap, reset abort and range drop.
module tb_ws2812b_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0]  valid0 = '0, valid1 = '0;
  logic [31:0] led0 = '0, led1 = '0;
  logic [95:0] col0 = '0, col1 = '0;
  logic [3:0]  ready0, ready1;
  logic [23:0] color0, color1;
  logic [31:0] nb0, nb1;
  logic        write0, write1, busy0, busy1;
  logic [15:0] drop0, drop1;
  int checks = 0, errors = 0, cyc = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  ws2812b_arbiter #(.N_REQ(4), .IDX_W(8), .NB_LEDS(15), .GAP_CYCLES(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_led(led0), .req_color(col0),
    .req_ready(ready0), .color(color0), .nb_led(nb0), .write(write0), .busy(busy0), .drop_cnt(drop0));
  ws2812b_arbiter #(.N_REQ(4), .IDX_W(8), .NB_LEDS(15), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_led(led1), .req_color(col1),
    .req_ready(ready1), .color(color1), .nb_led(nb1), .write(write1), .busy(busy1), .drop_cnt(drop1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev0 && rst) check("b2b_u0", 32'(write0), 0);
    if (prev1 && rst) check("b2b_u1", 32'(write1), 0);
    prev0 = write0;
    prev1 = write1;
  end

  task automatic set_req(input int i, input logic [7:0] led, input logic [23:0] c);
    led0[i*8 +: 8] = led;
    col0[i*24 +: 24] = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    valid0 = '0;
    valid1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_write", 32'(write0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_color", 32'(color0), 0);
    check("rst_nb_led", nb0, 0);
    check("rst_drop", 32'(drop0), 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_write(input string tag, output int led, output int t);
    led = -1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (write0) begin
        led = int'(nb0);
        t = cyc;
        return;
      end
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int led, t, n, nw;
    int leds[6];
    int ts[6];
    int exp_order[6] = '{1, 2, 3, 4, 1, 2};
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 24'h100000 * (i + 1));

    // single requester 2, led 5, green
    do_reset();
    set_req(2, 8'd5, 24'h00FF00);
    valid0 = 4'b0100;
    #1;
    check("t1_ready", 32'(ready0), 32'h4);
    @(negedge clk);
    valid0 = '0;
    #1;
    check("t1_write", 32'(write0), 1);
    check("t1_nb_led", nb0, 5);
    check("t1_color", 32'(color0), 32'h00FF00);
    check("t1_ready_low", 32'(ready0), 0);
    n = 1;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!busy0) break;
      n++;
      if (write0) nw++;
    end
    check("t1_busy_cycles", n, 17);
    check("t1_gap_writes", nw, 0);
    check("t1_color_hold", 32'(color0), 32'h00FF00);
    set_req(2, 8'd3, 24'h300000);

    // all four continuously valid: rotation and 18-cycle spacing
    do_reset();
    valid0 = 4'b1111;
    for (int k = 0; k < 6; k++) wait_write("t2", leds[k], ts[k]);
    for (int k = 0; k < 6; k++) check($sformatf("t2_order%0d", k), leds[k], exp_order[k]);
    for (int k = 1; k < 6; k++) check($sformatf("t2_space%0d", k), ts[k] - ts[k-1], 18);

    // 1 then {1,3}, then 0 joins mid-gap
    do_reset();
    valid0 = 4'b0010;
    wait_write("t3a", led, t);
    check("t3_g1", led, 2);
    valid0 = 4'b1010;
    wait_write("t3b", led, t);
    check("t3_g3", led, 4);
    repeat (4) @(negedge clk);
    valid0 = 4'b1011;
    wait_write("t3c", led, t);
    check("t3_g0", led, 1);
    wait_write("t3d", led, t);
    check("t3_g1b", led, 2);

    // zero gap on u1: writes every 2nd cycle
    do_reset();
    led1 = 32'd9;
    col1 = 96'h123456;
    valid1 = 4'b0001;
    n = 0;
    nw = 0;
    t = -1;
    for (int i = 0; i < 20 && nw < 4; i++) begin
      @(negedge clk);
      #1;
      if (write1) begin
        if (t >= 0) check($sformatf("t4_space%0d", nw), cyc - t, 2);
        t = cyc;
        nw++;
        check("t4_nb_led", nb1, 9);
      end
    end
    check("t4_writes", nw, 4);
    valid1 = '0;

    // reset during gap aborts, then requester 0 wins
    do_reset();
    valid0 = 4'b0100;
    wait_write("t5", led, t);
    check("t5_g2", led, 3);
    valid0 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("t5_in_gap", 32'(busy0), 1);
    rst = 1'b0;
    #1;
    check("t5_busy0", 32'(busy0), 0);
    check("t5_color0", 32'(color0), 0);
    check("t5_nb0", nb0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    valid0 = 4'b1111;
    #1;
    check("t5_ready", 32'(ready0), 32'h1);
    wait_write("t5b", led, t);
    check("t5_first", led, 1);

    // out-of-range index
    do_reset();
    set_req(0, 8'd15, 24'h0000AA);
    valid0 = 4'b0001;
    #1;
    check("t6_ready", 32'(ready0), 32'h1);
`ifdef WS2812B_ARB_BOUNDS_CHECK_EN
    @(negedge clk);
    valid0 = '0;
    #1;
    check("t6_no_write", 32'(write0), 0);
    check("t6_drop", 32'(drop0), 1);
    @(negedge clk);
    #1;
    check("t6_idle", 32'(busy0), 0);
    check("t6_color_kept", 32'(color0), 0);
    set_req(0, 8'd14, 24'h0000BB);
    valid0 = 4'b0001;
    wait_write("t6b", led, t);
    check("t6_led14", led, 14);
    check("t6_drop_kept", 32'(drop0), 1);
`else
    wait_write("t6", led, t);
    check("t6_led15", led, 15);
    check("t6_drop_zero", 32'(drop0), 0);
`endif
    valid0 = '0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
